// File: rtl/delivery_sequencer_pkg.sv
// Shared encodings for the delivery sequencer: FSM phases and command bit layout.
package delivery_sequencer_pkg;

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_DEPART = 3'd1,
    PH_UNLOAD = 3'd2,
    PH_RETURN = 3'd3,
    PH_DONE   = 3'd4,
    PH_ABORT  = 3'd5
  } phase_t;

  localparam int unsigned START_BIT = 6;
  localparam int unsigned DEST_LSB  = 0;
  localparam int unsigned DEST_W    = 3;

endpackage

// File: rtl/delivery_sequencer_sync_debounce.sv
// One input bit: 2-FF synchronizer followed by a stability counter; dout follows
// the synchronized input only after DEBOUNCE_CYCLES consecutive differing samples.
module delivery_sequencer_sync_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4096
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      cnt  <= '0;
      dout <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 == dout) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        dout <= s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/delivery_sequencer.sv
// Rover delivery trip sequencer: debounced command in, timed depart/unload/return
// FSM with PWM-gated wheel enables out.
module delivery_sequencer
  import delivery_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4096,
  parameter int unsigned SEG_CYCLES      = 1000000,
  parameter int unsigned DWELL_CYCLES    = 500000,
  parameter int unsigned PWM_PERIOD      = 1000,
  parameter int unsigned PWM_DUTY        = 600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] state,
  input  logic       end_reset,
  output logic       busy,
  output logic       done,
  output logic       cmd_err,
  output logic [2:0] phase,
  output logic [1:0] motor_en,
  output logic       motor_dir
);

  localparam int unsigned NIN  = DEST_W + 2;
  localparam int unsigned TMAX = (7 * SEG_CYCLES > DWELL_CYCLES) ? 7 * SEG_CYCLES : DWELL_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned PW   = $clog2(PWM_PERIOD + 1);
  localparam int unsigned HOLD = DEBOUNCE_CYCLES + 4;
  localparam int unsigned HW   = $clog2(HOLD + 1);

  logic [NIN-1:0]    raw;
  logic [NIN-1:0]    db;
  logic [DEST_W-1:0] dest_db;
  logic              start_db;
  logic              abort;
  logic              start_q;
  logic              start_rise;
  logic [HW-1:0]     hold_cnt;
  logic              settled;
  logic [PW-1:0]     pwm_cnt;
  logic              pwm;
  phase_t            phase_q;
  logic [TW-1:0]     timer;
  logic [DEST_W-1:0] dest_lat;
  logic              unused_cmd_bits;

  assign unused_cmd_bits = ^{state[7], state[5:3]};
  assign raw = {end_reset, state[START_BIT], state[DEST_LSB +: DEST_W]};

  for (genvar i = 0; i < NIN; i++) begin : g_in
    delivery_sequencer_sync_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk  (clk),
      .reset(reset),
      .din  (raw[i]),
      .dout (db[i])
    );
  end

  assign dest_db  = db[DEST_W-1:0];
  assign start_db = db[DEST_W];
  assign abort    = db[DEST_W+1];

  // Ignore start edges until the debouncer has had time to reflect the real
  // input after reset, so a start held through reset never triggers a trip.
  assign settled    = (hold_cnt == HW'(HOLD));
  assign start_rise = start_db & ~start_q & settled;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
      start_q  <= 1'b0;
    end else begin
      start_q <= start_db;
      if (!settled) hold_cnt <= hold_cnt + HW'(1);
    end
  end

  // Free-running PWM counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
    end else if (pwm_cnt == PW'(PWM_PERIOD - 1)) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PW'(1);
    end
  end

  assign pwm = (32'(pwm_cnt) < PWM_DUTY);

  function automatic logic [TW-1:0] seg_load(input logic [DEST_W-1:0] d);
    return TW'(d) * TW'(SEG_CYCLES) - TW'(1);
  endfunction

  // Trip FSM; outputs are registered alongside the phase they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q   <= PH_IDLE;
      timer     <= '0;
      dest_lat  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_err   <= 1'b0;
      motor_en  <= '0;
      motor_dir <= 1'b0;
    end else begin
      done    <= 1'b0;
      cmd_err <= 1'b0;
      if (abort && phase_q != PH_IDLE && phase_q != PH_ABORT) begin
        phase_q   <= PH_ABORT;
        busy      <= 1'b1;
        motor_en  <= '0;
        motor_dir <= 1'b0;
      end else begin
        case (phase_q)
          PH_IDLE: begin
            if (start_rise && !abort) begin
              if (dest_db != '0) begin
                phase_q   <= PH_DEPART;
                dest_lat  <= dest_db;
                timer     <= seg_load(dest_db);
                busy      <= 1'b1;
                motor_en  <= {2{pwm}};
                motor_dir <= 1'b1;
              end else begin
                cmd_err <= 1'b1;
              end
            end
          end
          PH_DEPART: begin
            if (timer == '0) begin
              phase_q   <= PH_UNLOAD;
              timer     <= TW'(DWELL_CYCLES - 1);
              motor_en  <= '0;
              motor_dir <= 1'b0;
            end else begin
              timer    <= timer - TW'(1);
              motor_en <= {2{pwm}};
            end
          end
          PH_UNLOAD: begin
            if (timer == '0) begin
              phase_q   <= PH_RETURN;
              timer     <= seg_load(dest_lat);
              motor_en  <= {2{pwm}};
              motor_dir <= 1'b0;
            end else begin
              timer <= timer - TW'(1);
            end
          end
          PH_RETURN: begin
            if (timer == '0) begin
              phase_q  <= PH_DONE;
              done     <= 1'b1;
              motor_en <= '0;
            end else begin
              timer    <= timer - TW'(1);
              motor_en <= {2{pwm}};
            end
          end
          PH_DONE: begin
            if (!start_db) begin
              phase_q <= PH_IDLE;
              busy    <= 1'b0;
            end
          end
          PH_ABORT: begin
            if (!abort) begin
              phase_q <= PH_IDLE;
              busy    <= 1'b0;
            end
          end
          default: begin
            phase_q   <= PH_IDLE;
            busy      <= 1'b0;
            motor_en  <= '0;
            motor_dir <= 1'b0;
          end
        endcase
      end
    end
  end

  assign phase = phase_q;

endmodule
